// File: rtl/f1_sweep_pkg.sv
// Shared constants and state encoding for the truth-table sweep controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package f1_sweep_pkg;

   // Number of input vectors swept and the width of the vector index
   localparam int NVEC  = 16;
   localparam int IDX_W = 4;
   // Error counter is one bit wider than the index so 16 fits
   localparam int CNT_W = 5;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_APPLY  = 2'd1;
   localparam state_t ST_SAMPLE = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/f1_sweep_if.sv
// Bundles the sweep controller's control, vector drive and result signals.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while a sweep is busy.
interface f1_sweep_if;

   logic                          start;
   logic                          abort;
   logic [f1_sweep_pkg::NVEC-1:0] expected;
   logic                          f_in;
   logic                          a;
   logic                          b;
   logic                          c;
   logic                          d;
   logic                          busy;
   logic                          done;
   logic                          valid;
   logic                          pass;
   logic [f1_sweep_pkg::NVEC-1:0] captured;
   logic [f1_sweep_pkg::CNT_W-1:0] err_cnt;
   logic [f1_sweep_pkg::IDX_W-1:0] first_fail;

   // Lab top / bench side: issues commands and closes the loop through f_in
   modport master (
      output start, abort, expected, f_in,
      input  a, b, c, d, busy, done, valid, pass, captured, err_cnt, first_fail
   );

   // Controller side
   modport slave (
      input  start, abort, expected, f_in,
      output a, b, c, d, busy, done, valid, pass, captured, err_cnt, first_fail
   );

endinterface

// File: rtl/f1_sweep_ctrl_settle_timer.sv
// Settle counter: counts cycles a vector has been held, flags the last one.
// Latency: expire is a compare on the registered count (same cycle).
// Backpressure: none; clr wins over en.
module settle_timer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   // Terminal count; SETTLE is limited to 1..15 so this fits in 4 bits
   localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

   logic [3:0] r_cnt;

   // Count held cycles while enabled, restart on clr
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign expire = (r_cnt == LAST_CNT);

endmodule

// File: rtl/f1_sweep_ctrl.sv
// Walks a 4-input function block through all 16 vectors and checks f against a truth table.
// Latency: done pulses 16*(SETTLE+1) cycles after the edge that accepts start.
// Backpressure: start ignored while busy; abort returns to IDLE at the next edge.
module f1_sweep_ctrl
   import f1_sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   f1_sweep_if.slave sw
);

   state_t            r_state;
   state_t            w_state_nxt;

   logic [IDX_W-1:0]  r_idx;
   logic [NVEC-1:0]   r_exp;
   logic [NVEC-1:0]   r_captured;
   logic [CNT_W-1:0]  r_err_cnt;
   logic [IDX_W-1:0]  r_first_fail;
   logic              r_fail_seen;
   logic              r_valid;
   logic              r_pass;

   logic              w_expire;
   logic              w_tmr_clr;
   logic              w_tmr_en;
   logic              w_accept;
   logic              w_last;
   logic              w_mismatch;
   logic              w_busy;
   logic              w_done;

   // abort takes priority over start when both arrive in IDLE
   assign w_accept   = (r_state == ST_IDLE) && sw.start && !sw.abort;
   assign w_last     = (r_idx == IDX_W'(NVEC - 1));
   assign w_mismatch = (sw.f_in != r_exp[r_idx]);

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_tmr_clr),
      .en     (w_tmr_en),
      .expire (w_expire)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: hold each vector SETTLE cycles, sample, advance
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_APPLY;
            end
         end
         ST_APPLY: begin
            if (sw.abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_expire) begin
               w_state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (sw.abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_APPLY;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State-decoded outputs: status flags and settle timer control
   always_comb begin
      w_busy    = (r_state != ST_IDLE);
      // An abort landing on the DONE cycle suppresses the completion pulse
      w_done    = (r_state == ST_DONE) && !sw.abort;
      // Timer restarts in IDLE and on every sample so each vector gets a full settle
      w_tmr_clr = (r_state == ST_IDLE) || (r_state == ST_SAMPLE);
      w_tmr_en  = (r_state == ST_APPLY);
   end

   // Sweep datapath: latch the table on start, accumulate per-vector results, publish on DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx        <= '0;
         r_exp        <= '0;
         r_captured   <= '0;
         r_err_cnt    <= '0;
         r_first_fail <= '0;
         r_fail_seen  <= 1'b0;
         r_valid      <= 1'b0;
         r_pass       <= 1'b0;
      end else if (w_accept) begin
         r_exp        <= sw.expected;
         r_idx        <= '0;
         r_captured   <= '0;
         r_err_cnt    <= '0;
         r_first_fail <= '0;
         r_fail_seen  <= 1'b0;
         r_valid      <= 1'b0;
      end else if ((r_state == ST_SAMPLE) && !sw.abort) begin
         r_captured[r_idx] <= sw.f_in;
         if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
            if (!r_fail_seen) begin
               r_first_fail <= r_idx;
               r_fail_seen  <= 1'b1;
            end
         end
         // idx parks at 15 after the last sample so a..d hold the final vector
         if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end else if ((r_state == ST_DONE) && !sw.abort) begin
         // err_cnt already includes the final sample by the time DONE is reached
         r_valid <= 1'b1;
         r_pass  <= (r_err_cnt == '0);
      end
   end

   // Vector drive straight from the index register keeps a..d glitch-free
   assign sw.a          = r_idx[3];
   assign sw.b          = r_idx[2];
   assign sw.c          = r_idx[1];
   assign sw.d          = r_idx[0];
   assign sw.busy       = w_busy;
   assign sw.done       = w_done;
   assign sw.valid      = r_valid;
   assign sw.pass       = r_pass;
   assign sw.captured   = r_captured;
   assign sw.err_cnt    = r_err_cnt;
   assign sw.first_fail = r_first_fail;

endmodule

// File: doc/f1_sweep_ctrl.md
# f1_sweep_ctrl

- **Function:** sequences a 4-input single-output combinational function block (inputs `a`, `b`, `c`, `d`; output `f`) through all 16 input vectors.
- **Per vector:** waits a programmable settle time, then samples the output.
- **Result:** compares the sampled value against a 16-bit expected truth table and reports pass/fail, error count and first failing vector.
- **Placement:** sits at lab top level beside the function implementation. It lets any of the alternative implementations of the same function be self-checked on hardware or in simulation.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before sampling. Legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  cancel a sweep in progress.
- `expected`  in  16  expected truth table; bit n = f for vector n. Latched at start.
- `f_in`  in  1  output of the function block under test.
- `a`, `b`, `c`, `d`  out  1 each  vector drive: a = idx[3], b = idx[2], c = idx[1], d = idx[0].
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on sweep completion.
- `valid`  out  1  result outputs hold a completed sweep.
- `pass`  out  1  captured == expected; meaningful only when valid = 1.
- `captured`  out  16  sampled f per vector.
- `err_cnt`  out  5  number of mismatching vectors, 0..16.
- `first_fail`  out  4  lowest mismatching index; 0 if none.

## Operation
- **State machine:** IDLE, APPLY, SAMPLE, DONE.
- **IDLE:**
  - `start` = 1 and `abort` = 0 at an edge: latch `expected`, then `idx` = 0, `wait_cnt` = 0, `captured` = 0, `err_cnt` = 0, `first_fail` = 0, `fail_seen` = 0, `valid` = 0.
  - Next state is APPLY.
- **APPLY:** `wait_cnt` increments each cycle. When `wait_cnt` == SETTLE-1, go to SAMPLE.
- **SAMPLE:**
  - `captured[idx]` <= `f_in`.
  - On mismatch with `expected[idx]`: `err_cnt` += 1. If `fail_seen` = 0, then `first_fail` <= `idx` and `fail_seen` <= 1.
  - If `idx` == 15, go to DONE. Otherwise `idx` += 1, `wait_cnt` = 0, go to APPLY.
- **DONE:**
  - `done` = 1 and `valid` <= 1.
  - `pass` <= (`err_cnt` == 0), using the final post-SAMPLE count.
  - Go to IDLE.
- **Vector outputs:** `a`..`d` are driven directly from the `idx` register, so they are glitch-free. They hold their last value in IDLE.
- **Widths:**
  - `idx` is 4 bits and never wraps within a sweep; the terminal test is `idx` == 15.
  - `err_cnt` is 5 bits so that a count of 16 is representable.
- **abort:**
  - In APPLY, SAMPLE or DONE: return to IDLE at the next edge. No `done` pulse, `valid` stays 0, and partial results stay visible but are invalid.
  - `abort` beats `start` when both are asserted in IDLE.
- **start outside IDLE:** ignored.
- **Reset values:**
  - Outputs: all 0, i.e. `a`..`d` = 0, `busy` = 0, `done` = 0, `valid` = 0, `pass` = 0, `captured` = 0, `err_cnt` = 0, `first_fail` = 0.
  - State is IDLE.
  - Reset mid-sweep takes effect at the next edge and overrides `start` and `abort`.

## Timing
- **Sweep length:** the edge that samples `start` is E0. `done` is high in the cycle after edge E0 + 16·(SETTLE+1). With SETTLE = 1 that is edge E0 + 32.
- **Per-vector timing:** vector n is driven from edge E0 + n·(SETTLE+1). `f_in` is sampled at edge E0 + n·(SETTLE+1) + SETTLE + 1.
- **busy:** rises at E0 and falls at the edge after the DONE cycle.
- **valid and pass:** registered simultaneously with the `done` cycle and held until the next accepted `start` or reset.
- **f_in path:** combinational from `a`..`d`. A settle of at least 1 cycle is required.

## Structure
- **Package `f1_sweep_pkg`:**
  - State encoding localparams: ST_IDLE, ST_APPLY, ST_SAMPLE, ST_DONE.
  - NVEC = 16 and IDX_W = 4.
- **Sub-module `settle_timer`:** a natural one to factor out.
  - Inputs: `clk`, `rst_n`, `clr`, `en`.
  - Output: `expire`, asserted when the count reaches SETTLE-1.
  - Instantiated once.
- **Function block under test:** external to this block and connected at top level.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles → all outputs 0 and `busy` = 0.
- **Passing sweep:** bench model f = table 16'hA5C3 indexed by {a,b,c,d}; `expected` = 16'hA5C3; SETTLE = 1; `start` pulse → `done` at E0 + 32, `captured` = 16'hA5C3, `pass` = 1, `err_cnt` = 0, `valid` = 1.
- **Single fault:** model 16'hA5C3, `expected` = 16'hA5C2 → `pass` = 0, `err_cnt` = 1, `first_fail` = 0. Repeat with `expected` = 16'h25C3 → `first_fail` = 15.
- **All faults:** `expected` = 16'h5A3C (the inverse of the model), SETTLE = 3 → `done` at E0 + 64, `err_cnt` = 16, `first_fail` = 0.
- **Abort:** assert `abort` at E0 + 10 → `busy` = 0 next cycle, no `done`, `valid` = 0. A fresh `start` then completes normally with correct results.
- **Illegal start and mid-sweep reset:** `start` pulsed while `busy` → ignored, timing unchanged. `rst_n` low at E0 + 20 → reset values next edge.
